topo_spawn_scheduler: RTL and testbench



---
 rtl/topo_spawn_scheduler_pkg.sv | 29 ++
 rtl/topo_spawn_scheduler_tick_prescaler.sv | 28 ++
 rtl/topo_spawn_scheduler.sv | 137 +++++++++++++
 tb/tb_topo_spawn_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/topo_spawn_scheduler_pkg.sv
// Shared definitions for the mole-spawn scheduler: FSM encodings, level limits
// and default game timing.
package topo_spawn_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_GAP  = 3'd1,
    SPAWN     = 3'd2,
    VISIBLE   = 3'd3,
    GAME_OVER = 3'd4
  } stateT;

  localparam int LVL_MIN = 1;
  localparam int LVL_MAX = 4;

  localparam int DEF_TICK_DIV   = 25000000;
  localparam int DEF_GAP_TICKS  = 2;
  localparam int DEF_BASE_TICKS = 8;
  localparam int DEF_STEP_TICKS = 2;
  localparam int DEF_MAX_MISSES = 3;

  // Level values outside 1..4 snap to the nearest playable level.
  function automatic logic [2:0] clampLevel(input logic [2:0] lvl);
    if (int'(lvl) < LVL_MIN) return 3'(LVL_MIN);
    if (int'(lvl) > LVL_MAX) return 3'(LVL_MAX);
    return lvl;
  endfunction

endpackage

// File: rtl/topo_spawn_scheduler_tick_prescaler.sv
// Game-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the last
// count as a tick; a synchronous clear restarts the tick period.
module topo_spawn_scheduler_tick_prescaler #(
  parameter int TICK_DIV = 25000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iClear,
  input  logic iCount,
  output logic oTick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || iClear) begin
      count <= '0;
    end else if (iCount) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign oTick = iCount && (count == LAST);

endmodule

// File: rtl/topo_spawn_scheduler.sv
// Whack-a-mole spawn controller: paces mole appearances, picks the cell, times
// how long each mole stays up, and tallies misses until game over.
module topo_spawn_scheduler
  import topo_spawn_scheduler_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int BASE_TICKS = DEF_BASE_TICKS,
  parameter int STEP_TICKS = DEF_STEP_TICKS,
  parameter int MAX_MISSES = DEF_MAX_MISSES
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iEnable,
  input  logic [2:0] iLevel,
  input  logic [3:0] iRand,
  input  logic       iHit,
  output logic       oPonerTopo,
  output logic [3:0] oCelda,
  output logic       oTopoActivo,
  output logic       oMiss,
  output logic [1:0] oMissCount,
  output logic       oGameOver
);

  // Handshake: none; oPonerTopo and oMiss are single-cycle strobes, all other
  // outputs are levels held until the FSM changes them.

  stateT       state;
  logic [15:0] tickCount;
  logic [15:0] visTicks;
  logic [3:0]  prevCell;
  logic        prevValid;
  logic        hitQ;

  logic        tick;
  logic        inCount;
  logic        hitEdge;
  logic        gapDone;
  logic        timeout;
  logic        preClear;
  logic [15:0] visNext;
  logic [3:0]  cellNext;
  logic [1:0]  missInc;

  assign inCount  = (state == WAIT_GAP) || (state == VISIBLE);
  assign hitEdge  = iHit && !hitQ;
  assign gapDone  = tick && (tickCount == 16'(GAP_TICKS - 1));
  assign timeout  = tick && (tickCount == visTicks - 16'd1);
  // Leaving VISIBLE straight into WAIT_GAP must restart the tick period too.
  assign preClear = !inCount || ((state == VISIBLE) && (hitEdge || timeout));

  assign visNext  = 16'(BASE_TICKS - (int'(clampLevel(iLevel)) - LVL_MIN) * STEP_TICKS);
  assign cellNext = (prevValid && (iRand == prevCell)) ? iRand + 4'd1 : iRand;
  assign missInc  = (oMissCount == 2'(MAX_MISSES)) ? oMissCount : oMissCount + 2'd1;

  topo_spawn_scheduler_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) uPrescaler (
    .Clock (Clock),
    .Reset (Reset),
    .iClear(preClear),
    .iCount(inCount),
    .oTick (tick)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      tickCount   <= '0;
      visTicks    <= '0;
      prevCell    <= '0;
      prevValid   <= 1'b0;
      hitQ        <= 1'b0;
      oPonerTopo  <= 1'b0;
      oCelda      <= '0;
      oTopoActivo <= 1'b0;
      oMiss       <= 1'b0;
      oMissCount  <= '0;
      oGameOver   <= 1'b0;
    end else begin
      hitQ       <= iHit;
      oPonerTopo <= 1'b0;
      oMiss      <= 1'b0;

      if (preClear) begin
        tickCount <= '0;
      end else if (tick) begin
        tickCount <= tickCount + 16'd1;
      end

      if ((state != GAME_OVER) && !iEnable) begin
        state       <= IDLE;
        oTopoActivo <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_GAP;
          WAIT_GAP: begin
            if (gapDone) state <= SPAWN;
          end
          SPAWN: begin
            state       <= VISIBLE;
            oCelda      <= cellNext;
            oPonerTopo  <= 1'b1;
            oTopoActivo <= 1'b1;
            prevCell    <= cellNext;
            prevValid   <= 1'b1;
            visTicks    <= visNext;
          end
          VISIBLE: begin
            // A hit in the timeout cycle still counts as a hit.
            if (hitEdge) begin
              oTopoActivo <= 1'b0;
              state       <= WAIT_GAP;
            end else if (timeout) begin
              oMiss       <= 1'b1;
              oMissCount  <= missInc;
              oTopoActivo <= 1'b0;
              if (missInc == 2'(MAX_MISSES)) begin
                state     <= GAME_OVER;
                oGameOver <= 1'b1;
              end else begin
                state <= WAIT_GAP;
              end
            end
          end
          GAME_OVER: begin
            oGameOver   <= 1'b1;
            oTopoActivo <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_topo_spawn_scheduler.sv
// Bench for topo_spawn_scheduler with a fast tick: spawn timing, visible time
// per level, hits, cell de-duplication, game over and enable handling.
module tb_topo_spawn_scheduler;

  localparam int TD   = 4;
  localparam int GAP  = 2;
  localparam int BASE = 8;
  localparam int STEP = 2;
  localparam int MAXM = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iEnable;
  logic [2:0] iLevel;
  logic [3:0] iRand;
  logic       iHit;
  logic       oPonerTopo;
  logic [3:0] oCelda;
  logic       oTopoActivo;
  logic       oMiss;
  logic [1:0] oMissCount;
  logic       oGameOver;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_prev_cell;
  bit         m_prev_valid;
  int         m_miss;
  int         m_lat;
  logic [3:0] exp_q[$];

  topo_spawn_scheduler #(
    .TICK_DIV  (TD),
    .GAP_TICKS (GAP),
    .BASE_TICKS(BASE),
    .STEP_TICKS(STEP),
    .MAX_MISSES(MAXM)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iEnable    (iEnable),
    .iLevel     (iLevel),
    .iRand      (iRand),
    .iHit       (iHit),
    .oPonerTopo (oPonerTopo),
    .oCelda     (oCelda),
    .oTopoActivo(oTopoActivo),
    .oMiss      (oMiss),
    .oMissCount (oMissCount),
    .oGameOver  (oGameOver)
  );

  // clock / watchdog
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic int model_vis(input int lvl);
    int l;
    l = (lvl < 1) ? 1 : ((lvl > 4) ? 4 : lvl);
    return BASE - (l - 1) * STEP;
  endfunction

  function automatic int model_cell(input int rnd);
    if (m_prev_valid && rnd == m_prev_cell) return (rnd + 1) % 16;
    return rnd;
  endfunction

  // driver tasks
  task automatic do_reset();
    Reset   = 1'b1;
    iEnable = 1'b0;
    iHit    = 1'b0;
    iLevel  = 3'd1;
    iRand   = 4'd0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    m_prev_valid = 1'b0;
    m_prev_cell  = 0;
    m_miss       = 0;
    exp_q.delete();
  endtask

  task automatic enable_game();
    iEnable = 1'b1;
    m_lat   = GAP * TD + 2;
  endtask

  task automatic wait_strobe(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge Clock);
      n++;
      if (oPonerTopo === 1'b1) ok = 1'b1;
    end
  endtask

  // One spawn; hit_n < 0 lets the mole time out, else iHit rises hit_n cycles after the strobe.
  task automatic do_round(input int lvl, input int rnd, input int hit_n, input string tag);
    int n;
    bit ok;
    int vis;
    logic [3:0] exp_cell;
    iLevel = lvl[2:0];
    iRand  = rnd[3:0];
    vis    = model_vis(lvl);
    exp_q.push_back(4'(model_cell(rnd)));
    wait_strobe(n, ok);
    total++;
    if (!ok || n != m_lat) begin
      bad++;
      $display("FAIL %s spawn_latency: got %0d cycles (seen=%0d) want %0d", tag, n, ok, m_lat);
    end
    exp_cell = exp_q.pop_front();
    if (!ok) return;
    total++;
    if (oCelda !== exp_cell) begin
      bad++;
      $display("FAIL %s cell: got %0d want %0d", tag, oCelda, exp_cell);
    end
    total++;
    if (oTopoActivo !== 1'b1) begin
      bad++;
      $display("FAIL %s active_on_spawn: got %b want 1", tag, oTopoActivo);
    end
    m_prev_cell  = int'(exp_cell);
    m_prev_valid = 1'b1;
    @(negedge Clock);
    total++;
    if (oPonerTopo !== 1'b0) begin
      bad++;
      $display("FAIL %s strobe_width: got %b want 0", tag, oPonerTopo);
    end
    if (hit_n >= 1) begin
      repeat (hit_n - 1) @(negedge Clock);
      iHit = 1'b1;
      @(negedge Clock);
      total++;
      if (oTopoActivo !== 1'b0 || oMiss !== 1'b0 || int'(oMissCount) != m_miss) begin
        bad++;
        $display("FAIL %s hit: got active=%b miss=%b count=%0d want 0 0 %0d",
                 tag, oTopoActivo, oMiss, oMissCount, m_miss);
      end
      iHit  = 1'b0;
      m_lat = GAP * TD + 1;
    end else begin
      n = 1;
      while (oMiss !== 1'b1 && n < 200) begin
        @(negedge Clock);
        n++;
      end
      total++;
      if (n != vis * TD) begin
        bad++;
        $display("FAIL %s miss_time: got %0d cycles want %0d", tag, n, vis * TD);
      end
      m_miss = (m_miss + 1 > MAXM) ? MAXM : m_miss + 1;
      total++;
      if (int'(oMissCount) != m_miss || oTopoActivo !== 1'b0 || oGameOver !== (m_miss == MAXM)) begin
        bad++;
        $display("FAIL %s miss_state: got count=%0d active=%b over=%b want %0d 0 %b",
                 tag, oMissCount, oTopoActivo, oGameOver, m_miss, (m_miss == MAXM));
      end
      @(negedge Clock);
      total++;
      if (oMiss !== 1'b0) begin
        bad++;
        $display("FAIL %s miss_width: got %b want 0", tag, oMiss);
      end
      m_lat = GAP * TD;
    end
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    total++;
    if (oPonerTopo !== 1'b0) begin bad++; $display("FAIL reset_poner: got %b want 0", oPonerTopo); end
    total++;
    if (oCelda !== 4'd0) begin bad++; $display("FAIL reset_celda: got %0d want 0", oCelda); end
    total++;
    if (oTopoActivo !== 1'b0) begin bad++; $display("FAIL reset_activo: got %b want 0", oTopoActivo); end
    total++;
    if (oMiss !== 1'b0) begin bad++; $display("FAIL reset_miss: got %b want 0", oMiss); end
    total++;
    if (oMissCount !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", oMissCount); end
    total++;
    if (oGameOver !== 1'b0) begin bad++; $display("FAIL reset_over: got %b want 0", oGameOver); end
  endtask

  task automatic test_first_spawn();
    do_reset();
    enable_game();
    do_round(1, 5, -1, "first_lvl1");
  endtask

  task automatic test_levels();
    do_round(4, 3, -1, "lvl4");
    do_reset();
    enable_game();
    do_round(7, 8, -1, "lvl7");
    do_round(0, 2, -1, "lvl0");
  endtask

  task automatic test_hit();
    do_reset();
    enable_game();
    do_round(2, 4, 2 * TD + 1, "hit_tick3");
    do_round(3, 11, model_vis(3) * TD - 1, "hit_at_timeout");
    do_round(1, 6, -1, "after_hits");
  endtask

  task automatic test_cell_wrap();
    do_reset();
    enable_game();
    do_round(1, 15, 1, "wrap_a");
    do_round(1, 15, 1, "wrap_b");
    do_round(1, 9, 1, "dup_a");
    do_round(1, 9, 1, "dup_b");
  endtask

  task automatic test_game_over();
    do_reset();
    enable_game();
    do_round(4, 1, -1, "over_1");
    do_round(4, 2, -1, "over_2");
    do_round(4, 3, -1, "over_3");
    for (int i = 0; i < 40; i++) begin
      iEnable = 1'($urandom_range(0, 1));
      iHit    = 1'($urandom_range(0, 1));
      iRand   = 4'($urandom_range(0, 15));
      @(negedge Clock);
      total++;
      if (oPonerTopo !== 1'b0 || oGameOver !== 1'b1 || oTopoActivo !== 1'b0 || oMissCount !== 2'(MAXM)) begin
        bad++;
        $display("FAIL over_hold cyc%0d: got poner=%b over=%b active=%b count=%0d want 0 1 0 %0d",
                 i, oPonerTopo, oGameOver, oTopoActivo, oMissCount, MAXM);
      end
    end
    do_reset();
    total++;
    if (oGameOver !== 1'b0 || oMissCount !== 2'd0 || oTopoActivo !== 1'b0 || oPonerTopo !== 1'b0) begin
      bad++;
      $display("FAIL over_reset: got over=%b count=%0d active=%b poner=%b want all 0",
               oGameOver, oMissCount, oTopoActivo, oPonerTopo);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    bit ok;
    do_reset();
    enable_game();
    do_round(4, 12, -1, "drop_pre");
    // drop in the middle of VISIBLE
    iLevel = 3'd1;
    iRand  = 4'd7;
    wait_strobe(n, ok);
    total++;
    if (!ok || n != m_lat || oCelda !== 4'(model_cell(7))) begin
      bad++;
      $display("FAIL drop_vis_spawn: got lat=%0d seen=%0d cell=%0d want %0d %0d", n, ok, oCelda, m_lat, model_cell(7));
    end
    m_prev_cell  = model_cell(7);
    m_prev_valid = 1'b1;
    repeat (5) @(negedge Clock);
    iEnable = 1'b0;
    @(negedge Clock);
    total++;
    if (oTopoActivo !== 1'b0 || int'(oMissCount) != m_miss) begin
      bad++;
      $display("FAIL drop_vis: got active=%b count=%0d want 0 %0d", oTopoActivo, oMissCount, m_miss);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      total++;
      if (oPonerTopo !== 1'b0 || oMiss !== 1'b0) begin
        bad++;
        $display("FAIL drop_idle cyc%0d: got poner=%b miss=%b want 0 0", i, oPonerTopo, oMiss);
      end
    end
    // drop exactly in the SPAWN cycle
    iRand   = 4'd3;
    iEnable = 1'b1;
    for (int i = 1; i <= 9 + 30; i++) begin
      @(negedge Clock);
      if (i == GAP * TD + 1) iEnable = 1'b0;
      total++;
      if (oPonerTopo !== 1'b0) begin
        bad++;
        $display("FAIL drop_spawn cyc%0d: got poner=%b want 0", i, oPonerTopo);
      end
    end
    total++;
    if (int'(oMissCount) != m_miss || oTopoActivo !== 1'b0) begin
      bad++;
      $display("FAIL drop_spawn_state: got count=%0d active=%b want %0d 0", oMissCount, oTopoActivo, m_miss);
    end
    // a level already high before VISIBLE is not a hit
    iHit = 1'b1;
    @(negedge Clock);
    enable_game();
    do_round(1, 3, -1, "held_hit");
    iHit = 1'b0;
  endtask

  task automatic test_random();
    int lvl;
    int rnd;
    int hit_n;
    do_reset();
    enable_game();
    for (int r = 0; r < 14; r++) begin
      lvl = $urandom_range(0, 7);
      if (m_prev_valid && $urandom_range(0, 2) == 0) rnd = m_prev_cell;
      else rnd = $urandom_range(0, 15);
      if (m_miss >= MAXM - 1 || $urandom_range(0, 1) == 1) hit_n = $urandom_range(1, model_vis(lvl) * TD - 1);
      else hit_n = -1;
      do_round(lvl, rnd, hit_n, $sformatf("rand%0d", r));
    end
  endtask

  // sequence + report
  initial begin
    test_reset();
    test_first_spawn();
    test_levels();
    test_hit();
    test_cell_wrap();
    test_game_over();
    test_enable_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
